func_rr_sched: RTL and testbench
================================

Name: func_rr_sched

Overview:
- Round-robin scheduler that shares one `func` unit (result = a^2 + floor(cbrt(b))) between N_REQ independent requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and sequences the `func` start/busy protocol.
- Returns each 16-bit result on a single tagged response channel with backpressure.
- Sits between the requester fabric and one `func` instance; it owns that instance's start, a and b inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must satisfy 2^ID_W >= N_REQ.
- TIMEOUT, 1023, maximum cycles to wait for f_busy to fall before aborting an operation.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  request valid, one bit per requester.
- req_a  in  8*N_REQ  operand a; requester i uses bits [8i+7:8i].
- req_b  in  8*N_REQ  operand b; same packing as req_a.
- req_ready  out  N_REQ  one-hot acceptance pulse.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_data  out  16  result of `func`.
- resp_err  out  1  set when the operation timed out; resp_data is then 0.
- sched_busy  out  1  high whenever the FSM is not in IDLE.
- f_start  out  1  to `func` start.
- f_a  out  8  to `func` a.
- f_b  out  8  to `func` b.
- f_busy  in  1  from `func` busy.
- f_result  in  16  from `func` result.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE.
  - All outputs go to 0: req_ready, resp_valid, resp_id, resp_data, resp_err, sched_busy, f_start, f_a, f_b.
  - Round-robin pointer last_grant = N_REQ-1, so requester 0 has first priority.
  - Reset mid-operation drops the in-flight request and any pending response without notification.
- FSM states: IDLE, ISSUE, ARM, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching from last_grant+1 upward, modulo N_REQ.
  - On that edge: pulse req_ready[g] for exactly one cycle, latch a, b and g, set last_grant = g, go to ISSUE.
  - A requester must hold req_valid and its operands until it sees req_ready.
  - Simultaneous requests resolve strictly by the round-robin order above.
- ISSUE:
  - f_start = 1 for exactly one cycle.
  - f_a and f_b carry the latched operands and stay stable through WAIT.
  - Next state is ARM.
- ARM:
  - One cycle in which f_busy is ignored. This covers `func` raising busy one cycle after start.
  - Clear the timeout counter; next state is WAIT.
- WAIT:
  - On the first cycle with f_busy==0: capture f_result into resp_data, set resp_err=0, go to RESP.
  - Otherwise increment the counter.
  - If the counter reaches TIMEOUT: set resp_data=0 and resp_err=1, go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err stay stable until resp_valid && resp_ready at a clock edge.
  - On that edge, resp_valid falls and the FSM returns to IDLE.
  - No new grant is issued on the handshake edge. Arbitration resumes on the next cycle.
- Throughput and latency:
  - Exactly one operation is in flight at a time.
  - Minimum latency from grant edge to resp_valid = 3 + (cycles f_busy stays high after ARM).
- Widths: f_result is passed through unmodified. Saturation or overflow is the job of `func`.
- sched_busy = (state != IDLE).

Test Plan:
- Single request: requester 0 sends a=3, b=8 → req_ready[0] pulses once, f_start pulses once, then resp_valid with resp_id=0, resp_data=11, resp_err=0.
- Round-robin fairness: all 4 requesters assert together with (4,27), (5,64), (10,10), (255,255) → responses arrive in id order 0,1,2,3 with data 19, 29, 102, 65031. Requester 0 then re-requests while requester 2 is also requesting → requester 2 is served before requester 0.
- Backpressure: resp_ready held low for 20 cycles after resp_valid → resp_id/data stay stable, no req_ready pulses, f_start stays low. Raising resp_ready for one cycle completes exactly one response.
- Timeout with TIMEOUT=15: `func` model holds f_busy high indefinitely → resp_valid with resp_err=1 and resp_data=0, 17 cycles after the f_start pulse. The next request then completes normally.
- Reset mid-operation: reset=0 while in WAIT → next cycle all outputs are 0 and sched_busy=0. After release, requester 0 has priority again: with requesters 0 and 3 both pending, requester 0 is granted first.
- Edge operands: (0,0) gives 0 and (1,1) gives 2, each with the correct resp_id. f_a and f_b must not change between ISSUE and RESP.

Source files
------------

// File: rtl/func_rr_sched.sv
// Round-robin scheduler that shares one `func` unit (a^2 + floor(cbrt(b)))
// between N_REQ requesters, one operation in flight, tagged response channel.
module func_rr_sched #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [15:0]          resp_data,
    output logic                 resp_err,
    output logic                 sched_busy,
    output logic                 f_start,
    output logic [7:0]           f_a,
    output logic [7:0]           f_b,
    input  logic                 f_busy,
    input  logic [15:0]          f_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [15:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              sched_busy_q, sched_busy_d;
    logic              f_start_q, f_start_d;
    logic [7:0]        f_a_q, f_a_d;
    logic [7:0]        f_b_q, f_b_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [7:0]        gnt_a, gnt_b;

    // First requesting index strictly after last_q, wrapping modulo N_REQ.
    always_comb begin : arb
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[ID_W-1:0];
                gnt_a     = req_a[8*idx +: 8];
                gnt_b     = req_b[8*idx +: 8];
            end
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        f_start_d    = 1'b0;
        f_a_d        = f_a_q;
        f_b_d        = f_b_q;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready_d[gnt_idx] = 1'b1;
                    id_d      = gnt_idx;
                    last_d    = gnt_idx;
                    f_a_d     = gnt_a;
                    f_b_d     = gnt_b;
                    f_start_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = ARM;
            // func raises busy one cycle after start, so busy is not trusted here.
            ARM: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!f_busy) begin
                    resp_data_d  = f_result;
                    resp_err_d   = 1'b0;
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        resp_data_d  = '0;
                        resp_err_d   = 1'b1;
                        resp_id_d    = id_q;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            // No grant on the handshake edge; arbitration resumes next cycle.
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sched_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_q       <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            sched_busy_q <= 1'b0;
            f_start_q    <= 1'b0;
            f_a_q        <= '0;
            f_b_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            sched_busy_q <= sched_busy_d;
            f_start_q    <= f_start_d;
            f_a_q        <= f_a_d;
            f_b_q        <= f_b_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign sched_busy = sched_busy_q;
    assign f_start    = f_start_q;
    assign f_a        = f_a_q;
    assign f_b        = f_b_q;

endmodule

// File: tb/tb_func_rr_sched.sv
// Directed bench for func_rr_sched: vector table plus hand-written
// round-robin, backpressure, timeout and mid-operation reset sequences.
module tb_func_rr_sched;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             resp_valid, resp_ready;
    logic [IDW-1:0]   resp_id;
    logic [15:0]      resp_data;
    logic             resp_err, sched_busy, f_start;
    logic [7:0]       f_a, f_b;
    logic             f_busy;
    logic [15:0]      f_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    func_rr_sched #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .sched_busy(sched_busy),
        .f_start(f_start), .f_a(f_a), .f_b(f_b), .f_busy(f_busy), .f_result(f_result)
    );

    // Behavioural func unit: busy from the cycle after start for lat+1 cycles.
    logic        hang = 1'b0;
    int          lat  = 1;
    int          bcnt = 0;
    logic [15:0] pend;

    function automatic logic [15:0] func_ref(logic [7:0] a, logic [7:0] b);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(b)) r++;
        return 16'(int'(a) * int'(a) + r);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            f_busy   <= 1'b0;
            f_result <= 16'h0;
        end else if (f_start) begin
            f_busy   <= 1'b1;
            bcnt     <= lat;
            pend     <= func_ref(f_a, f_b);
            f_result <= 16'hbeef;
        end else if (f_busy && !hang) begin
            if (bcnt == 0) begin
                f_busy   <= 1'b0;
                f_result <= pend;
            end else begin
                bcnt <= bcnt - 1;
            end
        end
    end

    int fs_cnt = 0;
    int rr_cnt = 0;
    always @(posedge clk) begin
        if (f_start) fs_cnt <= fs_cnt + 1;
        if (|req_ready) rr_cnt <= rr_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    task automatic set_req(int id, logic [7:0] a, logic [7:0] b);
        req_valid[id]     = 1'b1;
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_drop", {resp_valid, sched_busy, req_ready}, '0);
    endtask

    // Waits for the grant to id, then the response; bp = cycles of held-off resp_ready.
    task automatic serve(int id, logic [7:0] a, logic [7:0] b,
                         logic [15:0] exp_d, logic exp_e, int bp);
        int   k;
        int   fs0, rr0;
        logic stab;
        logic [18:0] snap;
        k = 0;
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (req_ready == '0) begin
            fail("grant_wait");
            return;
        end
        chk("grant_onehot", req_ready, 64'(1) << id);
        chk("issue_f", {f_start, f_a, f_b}, {1'b1, a, b});
        req_valid[id] = 1'b0;
        @(negedge clk);
        chk("ready_start_pulse", {req_ready, f_start}, '0);
        stab = 1'b1;
        k = 0;
        while (!resp_valid && k < 100) begin
            if ({f_a, f_b} !== {a, b}) stab = 1'b0;
            @(negedge clk);
            k++;
        end
        if (!resp_valid) begin
            fail("resp_wait");
            return;
        end
        chk("f_ab_stable", {stab, f_a, f_b}, {1'b1, a, b});
        chk("resp", {resp_id, resp_err, resp_data}, {id[1:0], exp_e, exp_d});
        if (bp > 0) begin
            fs0  = fs_cnt;
            rr0  = rr_cnt;
            snap = {resp_valid, resp_id, resp_data};
            stab = 1'b1;
            for (int j = 0; j < bp; j++) begin
                @(negedge clk);
                if ({resp_valid, resp_id, resp_data} !== snap) stab = 1'b0;
            end
            chk("bp_hold", {stab, 32'(fs_cnt - fs0), 16'(rr_cnt - rr0)}, {1'b1, 32'd0, 16'd0});
        end
        handshake();
    endtask

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int k;
        int fs0, rr0;

        tbl[0] = '{id: 0, a: 8'd3,   b: 8'd8,   lat: 2, exp: 16'd11};
        tbl[1] = '{id: 1, a: 8'd0,   b: 8'd0,   lat: 0, exp: 16'd0};
        tbl[2] = '{id: 2, a: 8'd1,   b: 8'd1,   lat: 3, exp: 16'd2};
        tbl[3] = '{id: 3, a: 8'd255, b: 8'd255, lat: 1, exp: 16'd65031};
        tbl[4] = '{id: 1, a: 8'd10,  b: 8'd10,  lat: 5, exp: 16'd102};

        do_reset();
        chk("reset_out", {req_ready, resp_valid, resp_id, resp_data, resp_err,
                          sched_busy, f_start, f_a, f_b}, '0);

        for (int i = 0; i < 5; i++) begin
            lat = tbl[i].lat;
            fs0 = fs_cnt;
            rr0 = rr_cnt;
            set_req(tbl[i].id, tbl[i].a, tbl[i].b);
            serve(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, 0);
            chk("one_start_one_ready", {32'(fs_cnt - fs0), 32'(rr_cnt - rr0)}, {32'd1, 32'd1});
        end

        // Round robin from a fresh reset; requester 0 re-requests after its turn.
        do_reset();
        lat = 1;
        set_req(0, 8'd4, 8'd27);
        set_req(1, 8'd5, 8'd64);
        set_req(2, 8'd10, 8'd10);
        set_req(3, 8'd255, 8'd255);
        serve(0, 8'd4, 8'd27, 16'd19, 1'b0, 0);
        set_req(0, 8'd3, 8'd8);
        serve(1, 8'd5, 8'd64, 16'd29, 1'b0, 0);
        serve(2, 8'd10, 8'd10, 16'd102, 1'b0, 0);
        serve(3, 8'd255, 8'd255, 16'd65031, 1'b0, 0);
        serve(0, 8'd3, 8'd8, 16'd11, 1'b0, 0);

        // Backpressure with another requester waiting.
        set_req(1, 8'd4, 8'd27);
        set_req(2, 8'd10, 8'd10);
        serve(1, 8'd4, 8'd27, 16'd19, 1'b0, 20);
        serve(2, 8'd10, 8'd10, 16'd102, 1'b0, 0);

        // Timeout: busy never falls.
        hang = 1'b1;
        set_req(3, 8'd7, 8'd7);
        k = 0;
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("to_grant", {req_ready, f_start}, {4'b1000, 1'b1});
        req_valid[3] = 1'b0;
        k = 0;
        while (!resp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("to_latency", 64'(k), 64'd17);
        chk("to_resp", {resp_valid, resp_id, resp_err, resp_data}, {1'b1, 2'd3, 1'b1, 16'd0});
        handshake();
        hang = 1'b0;
        repeat (3) @(negedge clk);
        set_req(0, 8'd1, 8'd1);
        serve(0, 8'd1, 8'd1, 16'd2, 1'b0, 0);

        // Reset while in WAIT, then check the pointer restarts at requester 0.
        hang = 1'b1;
        set_req(1, 8'd9, 8'd9);
        k = 0;
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_wait_busy", {sched_busy, resp_valid}, {1'b1, 1'b0});
        reset = 1'b0;
        set_req(3, 8'd6, 8'd27);
        set_req(0, 8'd2, 8'd8);
        @(negedge clk);
        chk("midop_reset_out", {req_ready, resp_valid, resp_id, resp_data, resp_err,
                                sched_busy, f_start, f_a, f_b}, '0);
        hang  = 1'b0;
        reset = 1'b1;
        serve(0, 8'd2, 8'd8, 16'd6, 1'b0, 0);
        serve(3, 8'd6, 8'd27, 16'd39, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
